// File: rtl/scan_chain_bist_ctrl.sv
// Scan-chain BIST sequencer: LFSR-driven shift patterns, single-cycle captures,
// a final flush, and MISR compaction of everything unloaded from the chain.
module scan_chain_bist_ctrl #(
    parameter int          CHAIN_LEN    = 8,
    parameter int          NUM_PATTERNS = 4,
    parameter logic [15:0] SEED         = 16'h0001
) (
    input  logic        CLK,
    input  logic        RSTB,
    input  logic        START,
    input  logic        ABORT,
    input  logic        SO,
    output logic        SE,
    output logic        SI,
    output logic        BUSY,
    output logic        DONE,
    output logic [15:0] SIGNATURE,
    output logic [15:0] PAT_CNT
);

    localparam int               CNT_W      = $clog2(CHAIN_LEN + 1);
    localparam logic [15:0]      SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [15:0]      LAST_PAT   = 16'(NUM_PATTERNS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_FLUSH,
        S_DONE
    } state_t;

    state_t           state;
    logic [15:0]      lfsr;
    logic [15:0]      misr;
    logic [CNT_W-1:0] shift_cnt;
    logic [15:0]      lfsr_next;
    logic [15:0]      misr_next;

    // Both registers use the same tap set; the MISR additionally folds SO into the MSB.
    assign lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign misr_next = {misr[0] ^ misr[2] ^ misr[3] ^ misr[5] ^ SO, misr[15:1]};

    // NOTE: every register here is assigned with <= so all next values are
    // computed from the same pre-edge state, independent of statement order.
    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            state     <= S_IDLE;
            lfsr      <= SEED_EFF;
            misr      <= '0;
            shift_cnt <= '0;
            SE        <= 1'b0;
            SI        <= 1'b0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            SIGNATURE <= '0;
            PAT_CNT   <= '0;
        end else if (ABORT) begin
            // Abandon the run silently; SIGNATURE and PAT_CNT keep whatever they hold.
            state <= S_IDLE;
            SE    <= 1'b0;
            SI    <= 1'b0;
            BUSY  <= 1'b0;
            DONE  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    DONE <= 1'b0;
                    if (START) begin
                        state     <= S_SHIFT;
                        lfsr      <= SEED_EFF;
                        misr      <= '0;
                        PAT_CNT   <= '0;
                        shift_cnt <= '0;
                        SE        <= 1'b1;
                        SI        <= SEED_EFF[0];
                        BUSY      <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    lfsr <= lfsr_next;
                    misr <= misr_next;
                    if (shift_cnt == LAST_SHIFT) begin
                        state     <= S_CAPTURE;
                        shift_cnt <= '0;
                        SE        <= 1'b0;
                        SI        <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                        SI        <= lfsr_next[0];
                    end
                end

                S_CAPTURE: begin
                    PAT_CNT   <= PAT_CNT + 16'd1;
                    shift_cnt <= '0;
                    SE        <= 1'b1;
                    if (PAT_CNT == LAST_PAT) begin
                        state <= S_FLUSH;
                        SI    <= 1'b0;
                    end else begin
                        state <= S_SHIFT;
                        SI    <= lfsr[0];
                    end
                end

                S_FLUSH: begin
                    misr <= misr_next;
                    if (shift_cnt == LAST_SHIFT) begin
                        // The last unloaded bit goes straight into SIGNATURE so it is valid with DONE.
                        state     <= S_DONE;
                        shift_cnt <= '0;
                        SE        <= 1'b0;
                        BUSY      <= 1'b0;
                        DONE      <= 1'b1;
                        SIGNATURE <= misr_next;
                    end else begin
                        shift_cnt <= shift_cnt + CNT_W'(1);
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                    DONE  <= 1'b0;
                end

                default: begin
                    state <= S_IDLE;
                    SE    <= 1'b0;
                    SI    <= 1'b0;
                    BUSY  <= 1'b0;
                    DONE  <= 1'b0;
                end
            endcase
        end
    end

endmodule
